// File: rtl/simple_fifo_param.sv
// Parametrised synchronous FIFO with registered or first-word-fall-through
// read, programmable almost-full/empty thresholds and sticky error flags.
module simple_fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = 3,
    parameter int FWFT      = 0,
    parameter int AF_LEVEL  = (1 << DEPTH_LOG) - 1,
    parameter int AE_LEVEL  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 we,
    input  logic [WIDTH-1:0]     din,
    input  logic                 re,
    output logic [WIDTH-1:0]     dout,
    output logic                 valid,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [DEPTH_LOG:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] C_DEPTH = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] C_AF    = (DEPTH_LOG + 1)'(AF_LEVEL);
    localparam logic [DEPTH_LOG:0] C_AE    = (DEPTH_LOG + 1)'(AE_LEVEL);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG-1:0] r_wr_ptr;
    logic [DEPTH_LOG-1:0] r_rd_ptr;
    logic [DEPTH_LOG:0]   r_count;
    logic [DEPTH_LOG:0]   w_count_nxt;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_ae;
    logic                 r_af;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 w_wr_ok;
    logic                 w_rd_ok;

    // Acceptance uses pre-edge flags: a pop never makes room for a
    // same-cycle push, and a push never feeds a same-cycle pop.
    assign w_wr_ok = we && !r_full && !flush;
    assign w_rd_ok = re && !r_empty && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ae     <= 1'b1;
            r_af     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_ok) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == C_DEPTH);
            r_ae    <= (w_count_nxt <= C_AE);
            r_af    <= (w_count_nxt >= C_AF);
            r_ovf   <= !flush && (r_ovf || (we && r_full));
            r_unf   <= !flush && (r_unf || (re && r_empty));
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally; forced to zero when empty.
            assign dout  = r_empty ? '0 : r_mem[r_rd_ptr];
            assign valid = !r_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_dout <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign dout  = r_dout;
            assign valid = r_valid;
        end
    endgenerate

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_ae;
    assign almost_full  = r_af;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_simple_fifo_param.sv
// Bench for simple_fifo_param: standard and FWFT instances share stimulus
// and are checked every cycle against a queue-based reference model.
module tb_simple_fifo_param;

    localparam int W  = 8;
    localparam int DL = 3;
    localparam int D  = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         we;
    logic         re;
    logic [W-1:0] din;

    logic [W-1:0] s_dout, f_dout;
    logic         s_valid, f_valid;
    logic         s_empty, f_empty;
    logic         s_full, f_full;
    logic         s_ae, f_ae;
    logic         s_af, f_af;
    logic [DL:0]  s_count, f_count;
    logic         s_ovf, f_ovf;
    logic         s_unf, f_unf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] q[$];
    logic         m_ovf;
    logic         m_unf;
    logic         m_valid;
    logic [W-1:0] m_dout;

    simple_fifo_param #(.WIDTH(W), .DEPTH_LOG(DL), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .flush(flush), .we(we), .din(din),
        .re(re), .dout(s_dout), .valid(s_valid), .empty(s_empty),
        .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    simple_fifo_param #(.WIDTH(W), .DEPTH_LOG(DL), .FWFT(1)) u_fw (
        .clk(clk), .reset(reset), .flush(flush), .we(we), .din(din),
        .re(re), .dout(f_dout), .valid(f_valid), .empty(f_empty),
        .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_dout  = '0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, "/s_count"}, 32'(s_count), 32'(n));
        chk({tag, "/s_empty"}, 32'(s_empty), 32'(n == 0));
        chk({tag, "/s_full"},  32'(s_full),  32'(n == D));
        chk({tag, "/s_ae"},    32'(s_ae),    32'(n <= 1));
        chk({tag, "/s_af"},    32'(s_af),    32'(n >= D - 1));
        chk({tag, "/s_ovf"},   32'(s_ovf),   32'(m_ovf));
        chk({tag, "/s_unf"},   32'(s_unf),   32'(m_unf));
        chk({tag, "/s_valid"}, 32'(s_valid), 32'(m_valid));
        chk({tag, "/s_dout"},  32'(s_dout),  32'(m_dout));
        chk({tag, "/f_count"}, 32'(f_count), 32'(n));
        chk({tag, "/f_empty"}, 32'(f_empty), 32'(n == 0));
        chk({tag, "/f_full"},  32'(f_full),  32'(n == D));
        chk({tag, "/f_ae"},    32'(f_ae),    32'(n <= 1));
        chk({tag, "/f_af"},    32'(f_af),    32'(n >= D - 1));
        chk({tag, "/f_ovf"},   32'(f_ovf),   32'(m_ovf));
        chk({tag, "/f_unf"},   32'(f_unf),   32'(m_unf));
        chk({tag, "/f_valid"}, 32'(f_valid), 32'(n != 0));
        if (n != 0) begin
            chk({tag, "/f_dout"}, 32'(f_dout), 32'(q[0]));
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check 1 after.
    task automatic step(input logic w, input logic [W-1:0] d,
                        input logic r, input logic f, input string tag);
        int n;
        @(negedge clk);
        we = w; din = d; re = r; flush = f;
        @(posedge clk);
        n = q.size();
        if (f) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            if (w && n == D) m_ovf = 1'b1;
            if (r && n == 0) m_unf = 1'b1;
            m_valid = r && (n != 0);
            if (m_valid) m_dout = q.pop_front();
            if (w && n != D) q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        flush = 1'b0; we = 1'b0; re = 1'b0; din = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        #1 check_all("reset_rel");

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0, "t1_wr");
            if (i == 7) chk("t1_af_at7", 32'(s_af), 32'd1);
        end
        chk("t1_full", 32'(s_full), 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, "t1_ovf");
        chk("t1_ovf_flag", 32'(s_ovf), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "t1_rd");
            chk("t1_rd_data", 32'(s_dout), 32'(i));
        end

        // Pointer wrap-around
        for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + W'(i), 1'b0, 1'b0, "t2_w6");
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t2_r6");
        for (int i = 0; i < 8; i++) step(1'b1, 8'hA0 + W'(i), 1'b0, 1'b0, "t2_w8");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "t2_r8");
            chk("t2_data", 32'(s_dout), 32'(8'hA0 + W'(i)));
        end
        chk("t2_empty", 32'(s_empty), 32'd1);

        // Simultaneous push/pop at mid, full and empty
        step(1'b0, 8'h00, 1'b0, 1'b1, "t3_flush");
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + W'(i), 1'b0, 1'b0, "t3_fill4");
        step(1'b1, 8'h4F, 1'b1, 1'b0, "t3_wr_rd4");
        chk("t3_cnt4", 32'(s_count), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + W'(i), 1'b0, 1'b0, "t3_fill8");
        step(1'b1, 8'h5F, 1'b1, 1'b0, "t3_wr_rd8");
        chk("t3_cnt7", 32'(s_count), 32'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t3_drain");
        step(1'b1, 8'h6A, 1'b1, 1'b0, "t3_wr_rd0");
        chk("t3_cnt1", 32'(s_count), 32'd1);
        chk("t3_unf", 32'(s_unf), 32'd1);
        chk("t3_valid0", 32'(s_valid), 32'd0);

        // FWFT fall-through of a single word
        step(1'b0, 8'h00, 1'b0, 1'b1, "t4_flush");
        step(1'b1, 8'h5A, 1'b0, 1'b0, "t4_wr");
        chk("t4_f_dout", 32'(f_dout), 32'h5A);
        chk("t4_f_valid", 32'(f_valid), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, "t4_rd");
        chk("t4_f_valid0", 32'(f_valid), 32'd0);
        chk("t4_f_empty", 32'(f_empty), 32'd1);

        // Flush overrides a write
        for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + W'(i), 1'b0, 1'b0, "t5_fill");
        step(1'b1, 8'hEE, 1'b0, 1'b1, "t5_flush_we");
        chk("t5_cnt0", 32'(s_count), 32'd0);
        step(1'b1, 8'h11, 1'b0, 1'b0, "t5_wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t5_rd");
        chk("t5_data", 32'(s_dout), 32'h11);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) step(1'b1, 8'h80 + W'(i), 1'b0, 1'b0, "t6_fill");
        @(negedge clk);
        we = 1'b1; din = 8'h33; re = 1'b0; flush = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("t6_async");
        @(negedge clk);
        reset = 1'b0; we = 1'b0;
        #1 check_all("t6_rel");
        step(1'b1, 8'h77, 1'b0, 1'b0, "t6_wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t6_rd");
        chk("t6_data", 32'(s_dout), 32'h77);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, W'($urandom),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 39) == 0,
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
